// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared serializer FSM state encoding and the detector pattern.
// Revision: 1.0  initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam logic [3:0] SEQ_PATTERN = 4'b1101;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : piso_serializer_if
// Brief   : Word handshake plus serial output bundle of the PISO serializer.
// Revision: 1.0  initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output din, din_valid,
        input  din_ready, x, x_valid, busy, frame_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x, x_valid, busy, frame_done
    );

endinterface : piso_serializer_if
`default_nettype wire

// File: rtl/piso_serializer_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : piso_shift_reg
// Brief   : Loadable shift register presenting the next serial bit, MSB or LSB first.
// Revision: 1.0  initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic [WIDTH-1:0] i_din,
    output logic                  o_bit
);

    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign o_bit     = r_sreg[WIDTH-1];
        end else begin : g_lsb
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign o_bit     = r_sreg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_din;
        end else if (i_shift) begin
            r_sreg <= w_shifted;
        end
    end

endmodule : piso_shift_reg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module  : piso_serializer
// Brief   : Parallel-in/serial-out stage streaming words bit-by-bit to the 1101
//           detector. Optional even-parity bit enabled by macro PISO_PARITY_EN.
// Revision: 1.0  initial release
// ============================================================================
module piso_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    piso_serializer_if.slave  bus
);

    localparam int              CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_data_bit;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_din   (bus.din),
        .o_bit   (w_data_bit)
    );

`ifdef PISO_PARITY_EN
    logic r_par;

    // Parity is taken from the word at accept so later din changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^bus.din;
        end
    end

    assign w_last = (r_state == ST_PARITY);
    assign bus.x  = (r_state == ST_IDLE)   ? IDLE_LEVEL :
                    (r_state == ST_PARITY) ? r_par      : w_data_bit;
`else
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == c_LAST);
    assign bus.x  = (r_state == ST_IDLE) ? IDLE_LEVEL : w_data_bit;
`endif

    assign w_ready  = (r_state == ST_IDLE) || w_last;
    assign w_accept = bus.din_valid && w_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_cnt != c_LAST) begin
                    w_cnt_nxt = r_cnt + c_ONE;
                    w_shift   = 1'b1;
                end else begin
                    w_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    // Accepting in the last bit cycle chains frames without a bubble.
                    w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
                    w_load      = w_accept;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                w_cnt_nxt   = '0;
                w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
                w_load      = w_accept;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.din_ready  = w_ready;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.x_valid    = (r_state != ST_IDLE);
    assign bus.frame_done = w_last;

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_piso_serializer
// Brief   : Directed vector bench for piso_serializer (MSB and LSB first builds).
// Revision: 1.0  initial release
// ============================================================================
module tb_piso_serializer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) bus_m ();
    piso_serializer_if #(.WIDTH(8)) bus_l ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_m.slave)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_l.slave)
    );

    typedef struct {
        logic       rstn;
        logic       vld;
        logic [7:0] din;
        logic       x;
        logic       xv;
        logic       rdy;
        logic       busy;
        logic       fd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_det    = 0;
    int   hist_n   = 0;
    logic [3:0] hist = 4'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic rs, input logic vl, input logic [7:0] d,
                        input logic ex, input logic exv, input logic erdy,
                        input logic ebusy, input logic efd);
        vec_t v;
        v.rstn = rs; v.vld = vl; v.din = d;
        v.x = ex; v.xv = exv; v.rdy = erdy; v.busy = ebusy; v.fd = efd;
        vecs.push_back(v);
    endtask

    task automatic push_idle(input logic vl, input logic [7:0] d);
        push(1'b1, vl, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // seq lists the expected bits on x in transmit order, leftmost first.
    task automatic push_frame(input logic [7:0] seq, input logic vl, input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            push(1'b1, vl, d, seq[7-i], 1'b1, (i == 7), 1'b1, (i == 7));
    endtask

    task automatic run_lsb_frame();
        logic [7:0] seq;
        seq = 8'b1101_0000;
        @(negedge clk);
        bus_l.din = 8'h0B; bus_l.din_valid = 1'b1;
        #1 chk("lsb_ready_idle", {7'b0, bus_l.din_ready}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_l.din_valid = 1'b0; bus_l.din = 8'hFF;
            #1;
            chk($sformatf("lsb_x[%0d]", i), {7'b0, bus_l.x}, {7'b0, seq[7-i]});
            chk($sformatf("lsb_fd[%0d]", i), {7'b0, bus_l.frame_done}, {7'b0, (i == 7)});
        end
        @(negedge clk);
        #1 chk("lsb_idle_xv", {7'b0, bus_l.x_valid}, 8'd0);
    endtask

    task automatic run_par_frame(input logic [8:0] seq, input logic vl, input logic [7:0] d);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus_m.din_valid = vl; bus_m.din = d;
            #1;
            chk($sformatf("par_x[%0d]", i), {7'b0, bus_m.x}, {7'b0, seq[8-i]});
            chk($sformatf("par_xv[%0d]", i), {7'b0, bus_m.x_valid}, 8'd1);
            chk($sformatf("par_rdy[%0d]", i), {7'b0, bus_m.din_ready}, {7'b0, (i == 8)});
            chk($sformatf("par_fd[%0d]", i), {7'b0, bus_m.frame_done}, {7'b0, (i == 8)});
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus_m.din = 8'h00; bus_m.din_valid = 1'b0;
        bus_l.din = 8'h00; bus_l.din_valid = 1'b0;
        repeat (2) @(negedge clk);

`ifdef PISO_PARITY_EN
        @(negedge clk);
        rstn = 1'b1; bus_m.din = 8'h07; bus_m.din_valid = 1'b1;
        #1 chk("par_reset_rdy", {7'b0, bus_m.din_ready}, 8'd1);
        run_par_frame({8'b0000_0111, 1'b1}, 1'b1, 8'h03);
        run_par_frame({8'b0000_0011, 1'b0}, 1'b0, 8'h00);
        @(negedge clk);
        #1 chk("par_idle_busy", {7'b0, bus_m.busy}, 8'd0);
`else
        // Single word: reset state then 8'hD0
        push_idle(1'b1, 8'hD0);
        push_frame(8'b1101_0000, 1'b0, 8'h00);
        // Back-to-back 0D/A5; A5 presented early must wait for the last bit
        push_idle(1'b1, 8'h0D);
        push_frame(8'b0000_1101, 1'b1, 8'hA5);
        push_frame(8'b1010_0101, 1'b0, 8'h00);
        // Pattern spanning a word boundary
        push_idle(1'b1, 8'h01);
        push_frame(8'b0000_0001, 1'b1, 8'hA0);
        push_frame(8'b1010_0000, 1'b0, 8'h00);
        // Reset after 3 bits of 8'hFF, then a full new word
        push_idle(1'b1, 8'hFF);
        push(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_idle(1'b1, 8'h96);
        push_frame(8'b1001_0110, 1'b0, 8'h00);
        push_idle(1'b0, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            rstn = vecs[i].rstn;
            bus_m.din_valid = vecs[i].vld;
            bus_m.din = vecs[i].din;
            #1;
            chk($sformatf("v%0d_x", i),    {7'b0, bus_m.x},          {7'b0, vecs[i].x});
            chk($sformatf("v%0d_xv", i),   {7'b0, bus_m.x_valid},    {7'b0, vecs[i].xv});
            chk($sformatf("v%0d_rdy", i),  {7'b0, bus_m.din_ready},  {7'b0, vecs[i].rdy});
            chk($sformatf("v%0d_busy", i), {7'b0, bus_m.busy},       {7'b0, vecs[i].busy});
            chk($sformatf("v%0d_fd", i),   {7'b0, bus_m.frame_done}, {7'b0, vecs[i].fd});
            if (bus_m.x_valid) begin
                hist = {hist[2:0], bus_m.x};
                hist_n++;
                if (hist_n >= 4 && hist == SEQ_PATTERN) n_det++;
            end else begin
                hist_n = 0;
            end
        end
        // D0 gives one, 0D|A5 two, 01|A0 one across the boundary, 96 none
        chk("detector_hits", n_det[7:0], 8'd4);

        run_lsb_frame();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire
